// File: rtl/ethernet_tx_framer.sv
// Buffers one layer-2 payload, then emits dst/src/EtherType header plus the
// 2-byte-realigned payload to the MAC as back-to-back 32-bit words.
module ethernet_tx_framer #(
   parameter int PACKET_DEPTH = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] our_mac_address,
   input  logic        tx_l2_start,
   input  logic [47:0] tx_l2_dst_mac,
   input  logic [15:0] tx_l2_ethertype,
   input  logic        tx_l2_data_valid,
   input  logic [2:0]  tx_l2_bytes_valid,
   input  logic [31:0] tx_l2_data,
   input  logic        tx_l2_commit,
   input  logic        tx_l2_drop,
   output logic        tx_l2_busy,
   input  logic        mac_tx_ready,
   output logic        mac_tx_start,
   output logic        mac_tx_data_valid,
   output logic [2:0]  mac_tx_bytes_valid,
   output logic [31:0] mac_tx_data,
   output logic        tx_overflow,
   output logic [2:0]  o_dbg_state
);
   localparam int AW = $clog2(PACKET_DEPTH);
   localparam int CW = AW + 3;

   typedef enum logic [2:0] {S_IDLE, S_BUFFER, S_SEND_WAIT, S_HEADER, S_BODY} state_t;

   state_t      r_state, w_next;
   logic [47:0] r_dst, r_src;
   logic [15:0] r_type;
   logic [AW:0] r_wr_ptr;
   logic [CW-1:0] r_byte_cnt, r_out_idx;
   logic        r_ovf, r_ovf_pulse;
   logic [31:0] r_mem [PACKET_DEPTH];

   logic        w_start_ok, w_full, w_accept, w_drop, w_commit, w_store, w_ovf_now;
   logic [CW-1:0] w_last_idx, w_hi_idx, w_lo_idx;
   logic [2:0]  w_last_bv, w_bv;
   logic [15:0] w_hi16, w_lo16;
   logic [31:0] w_word, w_mask;
   logic        w_valid;

   // Start wins over drop, drop wins over commit and data in the same cycle.
   always_comb begin
      w_start_ok = tx_l2_start && (r_state == S_IDLE || r_state == S_BUFFER);
      w_full     = (r_wr_ptr == (AW+1)'(PACKET_DEPTH));
      w_accept   = (r_state == S_BUFFER) && !tx_l2_start && !tx_l2_drop;
      w_drop     = (r_state == S_BUFFER) && !tx_l2_start && tx_l2_drop;
      w_commit   = w_accept && tx_l2_commit;
      w_store    = w_accept && tx_l2_data_valid && !w_full;
      w_ovf_now  = r_ovf || (w_accept && tx_l2_data_valid && w_full);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_start_ok) w_next = S_BUFFER;
         S_BUFFER: begin
            if (w_start_ok)    w_next = S_BUFFER;
            else if (w_drop)   w_next = S_IDLE;
            else if (w_commit) w_next = w_ovf_now ? S_IDLE : S_SEND_WAIT;
         end
         S_SEND_WAIT: if (mac_tx_ready) w_next = S_HEADER;
         S_HEADER:    if (r_out_idx == CW'(2)) w_next = S_BODY;
         S_BODY:      if (r_out_idx == w_last_idx) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_dst       <= '0;
         r_src       <= '0;
         r_type      <= '0;
         r_wr_ptr    <= '0;
         r_byte_cnt  <= '0;
         r_out_idx   <= '0;
         r_ovf       <= 1'b0;
         r_ovf_pulse <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_ovf_pulse <= w_commit && w_ovf_now;
         if (w_start_ok) begin
            r_dst      <= tx_l2_dst_mac;
            r_src      <= our_mac_address;
            r_type     <= tx_l2_ethertype;
            r_wr_ptr   <= '0;
            r_byte_cnt <= '0;
            r_ovf      <= 1'b0;
         end else begin
            if (w_store) begin
               r_wr_ptr   <= r_wr_ptr + 1'b1;
               r_byte_cnt <= r_byte_cnt + CW'(tx_l2_bytes_valid);
            end
            r_ovf <= w_ovf_now;
         end
         if (r_state == S_SEND_WAIT)
            r_out_idx <= '0;
         else if (r_state == S_HEADER || r_state == S_BODY)
            r_out_idx <= r_out_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= tx_l2_data;
   end

   // Output word k>=3 is {low half of payload word k-4 (or EtherType), high half of word k-3};
   // reads at or beyond the write pointer return zero.
   always_comb begin
      w_last_idx = (r_byte_cnt >> 2) + CW'(3) + {{(CW-1){1'b0}}, (r_byte_cnt[1:0] == 2'd3)};
      w_last_bv  = {1'b0, r_byte_cnt[1:0] + 2'd1} + 3'd1;
      w_hi_idx   = r_out_idx - CW'(3);
      w_lo_idx   = r_out_idx - CW'(4);
      w_hi16     = (w_hi_idx < CW'(r_wr_ptr)) ? r_mem[w_hi_idx[AW-1:0]][31:16] : 16'h0;
      if (r_out_idx == CW'(3))
         w_lo16 = r_type;
      else if (w_lo_idx < CW'(r_wr_ptr))
         w_lo16 = r_mem[w_lo_idx[AW-1:0]][15:0];
      else
         w_lo16 = 16'h0;
      if (r_out_idx == CW'(0))      w_word = r_dst[47:16];
      else if (r_out_idx == CW'(1)) w_word = {r_dst[15:0], r_src[47:32]};
      else if (r_out_idx == CW'(2)) w_word = r_src[31:0];
      else                          w_word = {w_lo16, w_hi16};
      w_bv = (r_state == S_BODY && r_out_idx == w_last_idx) ? w_last_bv : 3'd4;
      case (w_bv)
         3'd1:    w_mask = 32'hFF00_0000;
         3'd2:    w_mask = 32'hFFFF_0000;
         3'd3:    w_mask = 32'hFFFF_FF00;
         default: w_mask = 32'hFFFF_FFFF;
      endcase
      w_valid = (r_state == S_HEADER) || (r_state == S_BODY);
   end

   assign mac_tx_data_valid  = w_valid;
   assign mac_tx_bytes_valid = w_valid ? w_bv : 3'd0;
   assign mac_tx_data        = w_valid ? (w_word & w_mask) : 32'h0;
   assign mac_tx_start       = (r_state == S_SEND_WAIT) && mac_tx_ready;
   assign tx_l2_busy         = (r_state == S_SEND_WAIT) || w_valid;
   assign tx_overflow        = r_ovf_pulse;
   assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_ethernet_tx_framer.sv
// Directed bench for ethernet_tx_framer: table of frames with hand-computed
// output words, plus sequences for stall, overflow, drop, restart and reset.
module tb_ethernet_tx_framer;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] our_mac_address;
   logic        tx_l2_start;
   logic [47:0] tx_l2_dst_mac;
   logic [15:0] tx_l2_ethertype;
   logic        tx_l2_data_valid;
   logic [2:0]  tx_l2_bytes_valid;
   logic [31:0] tx_l2_data;
   logic        tx_l2_commit;
   logic        tx_l2_drop;
   logic        tx_l2_busy;
   logic        mac_tx_ready;
   logic        mac_tx_start;
   logic        mac_tx_data_valid;
   logic [2:0]  mac_tx_bytes_valid;
   logic [31:0] mac_tx_data;
   logic        tx_overflow;
   logic [2:0]  o_dbg_state;

   ethernet_tx_framer #(.PACKET_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .our_mac_address(our_mac_address),
      .tx_l2_start(tx_l2_start), .tx_l2_dst_mac(tx_l2_dst_mac),
      .tx_l2_ethertype(tx_l2_ethertype), .tx_l2_data_valid(tx_l2_data_valid),
      .tx_l2_bytes_valid(tx_l2_bytes_valid), .tx_l2_data(tx_l2_data),
      .tx_l2_commit(tx_l2_commit), .tx_l2_drop(tx_l2_drop), .tx_l2_busy(tx_l2_busy),
      .mac_tx_ready(mac_tx_ready), .mac_tx_start(mac_tx_start),
      .mac_tx_data_valid(mac_tx_data_valid), .mac_tx_bytes_valid(mac_tx_bytes_valid),
      .mac_tx_data(mac_tx_data), .tx_overflow(tx_overflow), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int start_cnt = 0;
   int ovf_cnt = 0;
   logic [31:0] exp_q[$];
   logic [2:0]  exp_bv_q[$];
   logic prev_start = 1'b0;
   logic prev_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard: every emitted word is matched against the expected queue.
   always @(negedge clk) begin
      if (mac_tx_start) start_cnt++;
      if (tx_overflow) ovf_cnt++;
      if (mac_tx_data_valid) begin
         if (!prev_valid) check("start_before_first_word", {31'b0, prev_start}, 32'd1);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h required=none", mac_tx_data);
         end else begin
            check("word_data", mac_tx_data, exp_q.pop_front());
            check("word_bv", {29'b0, mac_tx_bytes_valid}, {29'b0, exp_bv_q.pop_front()});
         end
      end else begin
         check("idle_data", mac_tx_data, 32'h0);
         check("idle_bv", {29'b0, mac_tx_bytes_valid}, 32'h0);
      end
      prev_start = mac_tx_start;
      prev_valid = mac_tx_data_valid;
   end

   typedef struct packed {
      logic [47:0]       dst;
      logic [47:0]       src;
      logic [15:0]       et;
      logic [2:0]        n_in;
      logic [3:0][31:0]  in_d;
      logic [3:0][2:0]   in_bv;
      logic [3:0]        n_out;
      logic [7:0][31:0]  out_d;
      logic [2:0]        last_bv;
   } vec_t;
   vec_t vecs[4];

   task automatic t_start(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
      tx_l2_start = 1'b1; tx_l2_dst_mac = dst; our_mac_address = src; tx_l2_ethertype = et;
      @(posedge clk); #1;
      tx_l2_start = 1'b0;
   endtask

   task automatic t_word(input logic [31:0] d, input logic [2:0] bv);
      tx_l2_data_valid = 1'b1; tx_l2_data = d; tx_l2_bytes_valid = bv;
      @(posedge clk); #1;
      tx_l2_data_valid = 1'b0; tx_l2_data = 32'h0; tx_l2_bytes_valid = 3'd0;
   endtask

   task automatic t_commit();
      tx_l2_commit = 1'b1;
      @(posedge clk); #1;
      tx_l2_commit = 1'b0;
   endtask

   task automatic t_idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [2:0] bv);
      exp_q.push_back(d);
      exp_bv_q.push_back(bv);
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || tx_l2_busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_drain"}, exp_q.size(), 32'd0);
      check({name, "_busy_end"}, {31'b0, tx_l2_busy}, 32'd0);
   endtask

   task automatic load_vec(input int k);
      t_start(vecs[k].dst, vecs[k].src, vecs[k].et);
      for (int i = 0; i < int'(vecs[k].n_in); i++) t_word(vecs[k].in_d[i], vecs[k].in_bv[i]);
      for (int i = 0; i < int'(vecs[k].n_out); i++)
         push_exp(vecs[k].out_d[i], (i == int'(vecs[k].n_out) - 1) ? vecs[k].last_bv : 3'd4);
   endtask

   task automatic run_vec(input int k);
      int s0 = start_cnt;
      load_vec(k);
      t_commit();
      wait_drain(60, $sformatf("v%0d", k));
      check($sformatf("v%0d_starts", k), 32'(start_cnt - s0), 32'd1);
   endtask

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int s0, o0, n;
      logic [7:0] bj, bk;
      rst = 1'b1; our_mac_address = '0; tx_l2_start = 0; tx_l2_dst_mac = '0;
      tx_l2_ethertype = '0; tx_l2_data_valid = 0; tx_l2_bytes_valid = '0; tx_l2_data = '0;
      tx_l2_commit = 0; tx_l2_drop = 0; mac_tx_ready = 1'b1;

      vecs[0] = '0;
      vecs[0].dst = 48'h020000000001; vecs[0].src = 48'h020000000002; vecs[0].et = 16'h0800;
      vecs[0].n_in = 3'd4;
      vecs[0].in_d[0] = 32'h11223344; vecs[0].in_d[1] = 32'h55667788;
      vecs[0].in_d[2] = 32'h99AABBCC; vecs[0].in_d[3] = 32'hDDEEFF00;
      for (int i = 0; i < 4; i++) vecs[0].in_bv[i] = 3'd4;
      vecs[0].n_out = 4'd8; vecs[0].last_bv = 3'd2;
      vecs[0].out_d[0] = 32'h02000000; vecs[0].out_d[1] = 32'h00010200;
      vecs[0].out_d[2] = 32'h00000002; vecs[0].out_d[3] = 32'h08001122;
      vecs[0].out_d[4] = 32'h33445566; vecs[0].out_d[5] = 32'h778899AA;
      vecs[0].out_d[6] = 32'hBBCCDDEE; vecs[0].out_d[7] = 32'hFF000000;

      vecs[1] = '0;
      vecs[1].dst = 48'hDA0102030405; vecs[1].src = 48'h5A0A0B0C0D0E; vecs[1].et = 16'h86DD;
      vecs[1].n_in = 3'd2;
      vecs[1].in_d[0] = 32'hAABBCCDD; vecs[1].in_bv[0] = 3'd4;
      vecs[1].in_d[1] = 32'hEE000000; vecs[1].in_bv[1] = 3'd1;
      vecs[1].n_out = 4'd5; vecs[1].last_bv = 3'd3;
      vecs[1].out_d[0] = 32'hDA010203; vecs[1].out_d[1] = 32'h04055A0A;
      vecs[1].out_d[2] = 32'h0B0C0D0E; vecs[1].out_d[3] = 32'h86DDAABB;
      vecs[1].out_d[4] = 32'hCCDDEE00;

      vecs[2] = '0;
      vecs[2].dst = 48'hFFFFFFFFFFFF; vecs[2].src = 48'h001122334455; vecs[2].et = 16'h88B5;
      vecs[2].n_in = 3'd1;
      vecs[2].in_d[0] = 32'hC0DE0000; vecs[2].in_bv[0] = 3'd2;
      vecs[2].n_out = 4'd4; vecs[2].last_bv = 3'd4;
      vecs[2].out_d[0] = 32'hFFFFFFFF; vecs[2].out_d[1] = 32'hFFFF0011;
      vecs[2].out_d[2] = 32'h22334455; vecs[2].out_d[3] = 32'h88B5C0DE;

      vecs[3] = '0;
      vecs[3].dst = 48'h010203040506; vecs[3].src = 48'h0A0B0C0D0E0F; vecs[3].et = 16'h0806;
      vecs[3].n_in = 3'd1;
      vecs[3].in_d[0] = 32'h12345600; vecs[3].in_bv[0] = 3'd3;
      vecs[3].n_out = 4'd5; vecs[3].last_bv = 3'd1;
      vecs[3].out_d[0] = 32'h01020304; vecs[3].out_d[1] = 32'h05060A0B;
      vecs[3].out_d[2] = 32'h0C0D0E0F; vecs[3].out_d[3] = 32'h08061234;
      vecs[3].out_d[4] = 32'h56000000;

      // Reset state
      #2;
      check("rst_busy", {31'b0, tx_l2_busy}, 32'd0);
      check("rst_start", {31'b0, mac_tx_start}, 32'd0);
      check("rst_valid", {31'b0, mac_tx_data_valid}, 32'd0);
      check("rst_overflow", {31'b0, tx_overflow}, 32'd0);
      check("rst_state", {29'b0, o_dbg_state}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      t_idle(2);

      for (int k = 0; k < 4; k++) run_vec(k);

      // Zero payload with MAC stalled for 10 cycles
      s0 = start_cnt;
      t_start(vecs[0].dst, vecs[0].src, 16'h0800);
      mac_tx_ready = 1'b0;
      push_exp(32'h02000000, 3'd4); push_exp(32'h00010200, 3'd4);
      push_exp(32'h00000002, 3'd4); push_exp(32'h08000000, 3'd2);
      t_commit();
      t_idle(10);
      check("stall_busy", {31'b0, tx_l2_busy}, 32'd1);
      check("stall_no_start", 32'(start_cnt - s0), 32'd0);
      check("stall_pending", exp_q.size(), 32'd4);
      mac_tx_ready = 1'b1;
      wait_drain(40, "zero_len");
      check("zero_len_starts", 32'(start_cnt - s0), 32'd1);

      // Exactly DEPTH words fits: 32 bytes -> 12 words, last bv 2
      s0 = start_cnt; o0 = ovf_cnt;
      t_start(vecs[0].dst, vecs[0].src, 16'h0800);
      for (int i = 0; i < DEPTH; i++) t_word(32'h01010101 * (i + 1), 3'd4);
      push_exp(32'h02000000, 3'd4); push_exp(32'h00010200, 3'd4);
      push_exp(32'h00000002, 3'd4); push_exp(32'h08000101, 3'd4);
      for (int j = 1; j < DEPTH; j++) begin
         bj = 8'(j); bk = 8'(j + 1);
         push_exp({bj, bj, bk, bk}, 3'd4);
      end
      push_exp(32'h08080000, 3'd2);
      t_commit();
      wait_drain(60, "full_depth");
      check("full_depth_starts", 32'(start_cnt - s0), 32'd1);
      check("full_depth_no_ovf", 32'(ovf_cnt - o0), 32'd0);

      // DEPTH+1 words -> overflow pulse, nothing sent
      s0 = start_cnt; o0 = ovf_cnt;
      t_start(vecs[0].dst, vecs[0].src, 16'h0800);
      for (int i = 0; i <= DEPTH; i++) t_word(32'hA5A50000 + 32'(i), 3'd4);
      t_commit();
      t_idle(5);
      check("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
      check("ovf_no_start", 32'(start_cnt - s0), 32'd0);
      check("ovf_busy", {31'b0, tx_l2_busy}, 32'd0);
      check("ovf_state_idle", {29'b0, o_dbg_state}, 32'd0);

      // Drop and commit in the same cycle
      s0 = start_cnt;
      t_start(vecs[1].dst, vecs[1].src, 16'h0800);
      t_word(32'h01020304, 3'd4);
      t_word(32'h05060708, 3'd4);
      tx_l2_drop = 1'b1; tx_l2_commit = 1'b1;
      @(posedge clk); #1;
      tx_l2_drop = 1'b0; tx_l2_commit = 1'b0;
      t_idle(20);
      check("drop_no_start", 32'(start_cnt - s0), 32'd0);
      check("drop_busy", {31'b0, tx_l2_busy}, 32'd0);

      // Restart while 3 words are buffered: only the new frame goes out
      t_start(vecs[0].dst, vecs[0].src, vecs[0].et);
      for (int i = 0; i < 3; i++) t_word(32'hDEAD0000 + 32'(i), 3'd4);
      run_vec(1);

      // Reset while the fifth output word is on the bus
      s0 = start_cnt;
      load_vec(0);
      t_commit();
      n = 0;
      while (exp_q.size() > 4 && n < 40) begin @(negedge clk); n++; end
      check("rst_mid_reached", exp_q.size(), 32'd4);
      @(posedge clk); #2;
      check("rst_mid_valid_before", {31'b0, mac_tx_data_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", {31'b0, mac_tx_data_valid}, 32'd0);
      check("rst_mid_busy", {31'b0, tx_l2_busy}, 32'd0);
      check("rst_mid_data", mac_tx_data, 32'h0);
      exp_q.delete();
      exp_bv_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      t_idle(20);
      check("rst_mid_no_resume", 32'(start_cnt - s0), 32'd1);
      run_vec(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ethernet_tx_framer.md
ETHERNET_TX_FRAMER -- requirements
Module: ethernet_tx_framer

Interface
REQ-001 SHALL have parameter PACKET_DEPTH, default 512, payload buffer depth in 32-bit words (power of two).
REQ-002 SHALL have: clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have: our_mac_address  input  48  source MAC, sampled on tx_l2_start.
REQ-005 SHALL have: tx_l2_start  input  1  begins a new frame, discarding any unsent buffered frame.
REQ-006 SHALL have: tx_l2_dst_mac  input  48  destination MAC, sampled with tx_l2_start.
REQ-007 SHALL have: tx_l2_ethertype  input  16  EtherType, sampled with tx_l2_start.
REQ-008 SHALL have: tx_l2_data_valid  input  1  payload word strobe.
REQ-009 SHALL have: tx_l2_bytes_valid  input  3  valid bytes (1-4, MSB-first); less than 4 only on the last word.
REQ-010 SHALL have: tx_l2_data  input  32  payload word, byte 0 in [31:24].
REQ-011 SHALL have: tx_l2_commit  input  1  frame complete, send it.
REQ-012 SHALL have: tx_l2_drop  input  1  abort frame, discard buffer.
REQ-013 SHALL have: tx_l2_busy  output  1  high in states SEND_WAIT, HEADER, BODY; producer SHALL NOT assert start while high.
REQ-014 SHALL have: mac_tx_ready  input  1  MAC can accept a new frame.
REQ-015 SHALL have: mac_tx_start  output  1  one-cycle pulse, cycle before the first output word.
REQ-016 SHALL have: mac_tx_data_valid, mac_tx_bytes_valid[2:0], mac_tx_data[31:0]  outputs  frame words, same byte order as input.
REQ-017 SHALL have: tx_overflow  output  1  one-cycle pulse when a committed frame is discarded for overflow.

Function
REQ-018 SHALL implement states IDLE, BUFFER, SEND_WAIT, HEADER, BODY.
REQ-019 IDLE/BUFFER + tx_l2_start -> BUFFER; latch dst, ethertype, src; write pointer=0; overflow flag cleared; byte count=0.
REQ-020 BUFFER + data_valid -> store word, byte count += bytes_valid; if PACKET_DEPTH words already stored, set overflow flag and do not store.
REQ-021 BUFFER + commit -> SEND_WAIT, or IDLE with tx_overflow pulse if overflow flag set.
REQ-022 BUFFER + drop -> IDLE, nothing emitted; drop has priority over commit and data_valid in the same cycle; start has priority over drop.
REQ-023 SEND_WAIT + mac_tx_ready -> HEADER with mac_tx_start pulse; otherwise hold.
REQ-024 HEADER SHALL emit 3 words: dst[47:16]; {dst[15:0], src[47:32]}; src[31:0]; all bytes_valid=4.
REQ-025 Fourth word SHALL be {ethertype, payload bytes 0-1}; payload thereafter realigned by 2 bytes; one word per cycle, no gaps, mac_tx_ready ignored after start.
REQ-026 For payload length N bytes: output words = ceil((14+N)/4); last bytes_valid = ((13+N) mod 4)+1; all earlier words 4.
REQ-027 N=0 SHALL emit 4 words, last = {ethertype, 16'h0} with bytes_valid=2.
REQ-028 After the last word -> IDLE; tx_l2_* inputs other than start ignored in SEND_WAIT/HEADER/BODY.
REQ-029 data_valid/commit/drop in IDLE SHALL be ignored.
REQ-030 Byte count SHALL be wide enough for PACKET_DEPTH*4 without wrap; read pointer SHALL not pass write pointer.
REQ-031 mac_tx_data_valid SHALL be low outside HEADER/BODY; mac_tx_data/bytes_valid don't-care when invalid but SHALL be 0 when invalid.

Reset
REQ-032 rst high SHALL force IDLE asynchronously; all outputs 0 (tx_l2_busy, mac_tx_start, mac_tx_data_valid, mac_tx_bytes_valid, mac_tx_data, tx_overflow); buffered frame discarded.
REQ-033 Reset mid-frame SHALL truncate output immediately; no partial frame resumes after deassertion.

Verification
REQ-034 dst=02:00:00:00:00:01, src=02:00:00:00:00:02, type=0x0800, payload 4 words 0x11223344,.. (16B), ready=1 -> start pulse, 8 words, first 0x02000000, fourth 0x08001122, last bytes_valid=2.
REQ-035 Payload 5 bytes (0xAABBCCDD, 0xEE/bv=1) -> 5 words, fifth = 0xEE000000 region with bytes_valid=3 (19 bytes total).
REQ-036 Zero payload, commit, ready held low 10 cycles -> busy high, no start until ready; then 4 words, last 0x08000000 bv=2.
REQ-037 PACKET_DEPTH+1 words then commit -> tx_overflow one pulse, no mac_tx_start, returns IDLE.
REQ-038 drop and commit same cycle -> nothing emitted; start during BUFFER with 3 words held -> only new frame emitted.
REQ-039 rst asserted during BODY word 5 -> mac_tx_data_valid 0 same cycle, busy 0; next frame sent intact.
